data_io_scan: RTL
=================

Name: data_io_scan

Overview:
- Parametrised successor to the board display/key I/O block.
- Drives a DIGITS-wide multiplexed 7-segment display from an internally divided scan tick.
- Debounces two push keys into a two-digit BCD entry value fed to the SoPC.
- Shows either entry+PC or the CPU result, selected by the SoPC out flag.
- Sits between the board pins and openmips_spoc, running on the 50 MHz board clock.

Parameters:
- DIGITS, 8, number of display digits (2..16).
- SEL_W, 3, width of the binary digit-select output (2^SEL_W >= DIGITS).
- SCAN_DIV, 50000, clk cycles per scan tick (>= 2).
- DEB_TICKS, 20, consecutive stable scan ticks required to accept a key level change (>= 1).
- DATA_W, 32, width of pc_in, res_in and data_o.

Ports:
- clk  input  1  board clock.
- rst  input  1  asynchronous reset, active-low.
- k1_ten  input  1  raw tens key, active-low, asynchronous to clk.
- k2_ge  input  1  raw ones key, active-low, asynchronous to clk.
- pc_in  input  DATA_W  current CPU PC.
- res_in  input  DATA_W  CPU result word.
- out_i  input  1  1 = result mode, 0 = entry mode.
- data_o  output  DATA_W  entered value, binary, tens*10+ones, zero-extended.
- sel  output  SEL_W  binary index of the active digit.
- seg  output  8  active-low segments, seg[7]=dp, seg[6:0]=g..a.

Behaviour:
- Reset (rst=0, asynchronous): sel=0, seg=8'hFF, data_o=0. Tick counter, digit index, BCD digits, debounce counters and synchronisers are cleared. Debounced key state is 1 (released).
- Scan tick:
  - Counter counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted for one clk cycle when the count equals SCAN_DIV-1.
  - The first tick occurs SCAN_DIV cycles after reset release.
- Scan:
  - On each tick, idx increments and wraps from DIGITS-1 to 0.
  - sel and seg are registered and update in the same clk cycle as each other, both reflecting the new idx.
- Digit source for digit k:
  - out_i=1: res_in[4k+3:4k] as hex.
  - out_i=0: k=0 shows ones BCD, k=1 shows tens BCD, k>=2 shows pc_in[4(k-2)+3:4(k-2)].
  - Nibbles beyond DATA_W show 0.
- Segment codes, seg[6:0]:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
  - dp is always 1 (off).
- Keys:
  - Two-flop synchroniser per key; debouncing is evaluated only on ticks.
  - On a tick where the synced level differs from the debounced state, the counter increments. When it reaches DEB_TICKS, the debounced state takes the synced level and the counter clears.
  - On a tick where the levels match, the counter clears.
  - A glitch shorter than DEB_TICKS ticks has no effect.
- Entry:
  - A debounced 1->0 transition is a press event and increments the corresponding BCD digit in that cycle.
  - Wrap 9->0 with no carry from ones into tens.
  - Release produces no action. Holding a key produces no auto-repeat.
  - Both keys pressed on the same tick increment both digits.
  - data_o is registered and updates 1 clk after the digit change.
- Reset asserted mid-press clears the entry value. After release, a key still held produces no press event until it has been released and pressed again.
- out_i changes take effect on the next scanned digit; no tearing within a digit.

Optional Feature:
- Macro: DATA_IO_SCAN_BLANK_EN.
- Defined: in result mode (out_i=1), each leading zero digit above digit 0 shows seg=8'hFF. Digit 0 is never blanked. Entry mode is unaffected.
- Undefined: all digits are always shown.

Test Plan:
- Reset held, then released (DIGITS=8, SCAN_DIV=4) -> sel=0 and seg=FF during reset; sel then steps 1,2..7,0 every 4 clks.
- out_i=1, res_in=32'h0000002A -> sel=0 gives seg=88, sel=1 gives seg=A4, sel=2..7 give seg=C0 (blank build: FF).
- k2_ge held low 3 separate times, each longer than DEB_TICKS ticks (DEB_TICKS=2) -> data_o=3; a 1-tick low pulse leaves data_o=3.
- Press k1_ten 10 times with ones=3 -> data_o sequence 13,23..93,3 (tens wraps to 0).
- Both keys pressed together from entry 0 -> data_o=11 in a single update. With out_i=0 and pc_in=32'h1234, sel=2 gives seg=99 (digit '4'), sel=3 gives seg=B0 (digit '3').
- Entry 45, then rst pulsed low mid-press with the key still held after release -> data_o=0 and no increment until the key is released and pressed again.

Source files
------------

// File: rtl/data_io_scan.sv
// -----------------------------------------------------------------------------
// data_io_scan
//   Board-side display/key block that sits between the pins and openmips_spoc.
//   - Divides clk down to a scan tick and walks a DIGITS-wide multiplexed
//     7-segment display (binary digit select + active-low segments).
//   - Debounces two active-low push keys into a two-digit BCD entry value,
//     presented to the SoPC as binary (tens*10 + ones).
//   - Shows entry value + PC (out_i=0) or the CPU result word (out_i=1).
//
// Optional build macro:
//   DATA_IO_SCAN_BLANK_EN - in result mode, leading zero digits above digit 0
//                           are blanked (seg = 8'hFF).
//
// Ports:
//   clk     in   board clock (50 MHz)
//   rst     in   asynchronous reset, active-low
//   k1_ten  in   raw tens key, active-low, asynchronous
//   k2_ge   in   raw ones key, active-low, asynchronous
//   pc_in   in   [DATA_W-1:0] current CPU PC
//   res_in  in   [DATA_W-1:0] CPU result word
//   out_i   in   1 = result mode, 0 = entry mode
//   data_o  out  [DATA_W-1:0] entered value, binary, zero-extended
//   sel     out  [SEL_W-1:0] index of the active digit
//   seg     out  [7:0] active-low segments, seg[7]=dp, seg[6:0]=g..a
// -----------------------------------------------------------------------------
module data_io_scan #(
  parameter int DIGITS    = 8,
  parameter int SEL_W     = 3,
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 20,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              k1_ten,
  input  logic              k2_ge,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] res_in,
  input  logic              out_i,
  output logic [DATA_W-1:0] data_o,
  output logic [SEL_W-1:0]  sel,
  output logic [7:0]        seg
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DC_W  = (DEB_TICKS < 2) ? 1 : $clog2(DEB_TICKS + 1);
  // Wide enough that every displayable nibble exists; nibbles past DATA_W are 0.
  localparam int EXT_W = 4 * DIGITS + DATA_W;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'h0: seg_code = 7'h40;
      4'h1: seg_code = 7'h79;
      4'h2: seg_code = 7'h24;
      4'h3: seg_code = 7'h30;
      4'h4: seg_code = 7'h19;
      4'h5: seg_code = 7'h12;
      4'h6: seg_code = 7'h02;
      4'h7: seg_code = 7'h78;
      4'h8: seg_code = 7'h00;
      4'h9: seg_code = 7'h10;
      4'hA: seg_code = 7'h08;
      4'hB: seg_code = 7'h03;
      4'hC: seg_code = 7'h46;
      4'hD: seg_code = 7'h21;
      4'hE: seg_code = 7'h06;
      default: seg_code = 7'h0E;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Scan tick divider
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == CNT_W'(SCAN_DIV - 1));

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Key synchronise + debounce. Bit 1 = tens key, bit 0 = ones key.
  // ---------------------------------------------------------------------------
  logic [1:0]      raw_keys, sync1, sync2, deb, armed, press;
  logic [DC_W-1:0] deb_cnt [2];

  assign raw_keys = {k1_ten, k2_ge};

  // A key is armed only once it has been seen released after reset, so a key
  // held through reset cannot produce a press until released and pressed anew.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      press[i] = tick && armed[i] && deb[i] && !sync2[i] &&
                 (deb_cnt[i] == DC_W'(DEB_TICKS - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= 2'b11;
      armed <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw_keys;
      sync2 <= sync1;
      if (tick) begin
        for (int i = 0; i < 2; i++) begin
          if (sync2[i] != deb[i]) begin
            if (deb_cnt[i] == DC_W'(DEB_TICKS - 1)) begin
              deb[i]     <= sync2[i];
              deb_cnt[i] <= '0;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
          end else begin
            deb_cnt[i] <= '0;
            if (sync2[i]) armed[i] <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BCD entry digits and binary output
  // ---------------------------------------------------------------------------
  logic [3:0] ones, tens;
  logic [7:0] entry_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones <= '0;
      tens <= '0;
    end else begin
      // Independent wrap; no carry from ones into tens.
      if (press[0]) ones <= (ones == 4'd9) ? 4'd0 : ones + 4'd1;
      if (press[1]) tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end
  end

  assign entry_val = {4'd0, tens} * 8'd10 + {4'd0, ones};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_o <= '0;
    else      data_o <= DATA_W'(entry_val);
  end

  // ---------------------------------------------------------------------------
  // Digit source and segment register
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] idx_next;
  logic [31:0]      dig_k;
  logic [EXT_W-1:0] res_ext, pc_ext;
  logic [3:0]       nib;
  logic             blank;

  assign idx_next = (sel == SEL_W'(DIGITS - 1)) ? '0 : sel + 1'b1;
  assign dig_k    = 32'(idx_next);
  assign res_ext  = EXT_W'(res_in);
  assign pc_ext   = EXT_W'(pc_in);

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    nib   = '0;
    blank = 1'b0;
    if (out_i) begin
      nib = 4'(res_ext >> (4 * dig_k));
`ifdef DATA_IO_SCAN_BLANK_EN
      // Leading zero: this nibble and everything above it are zero.
      blank = (dig_k != 0) && ((res_ext >> (4 * dig_k)) == '0);
`endif
    end else if (dig_k == 0) begin
      nib = ones;
    end else if (dig_k == 1) begin
      nib = tens;
    end else begin
      nib = 4'(pc_ext >> (4 * (dig_k - 2)));
    end
  end

  // sel and seg change together on the tick, both describing the new digit,
  // so a mode change never tears a digit mid-display.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel <= '0;
      seg <= 8'hFF;
    end else if (tick) begin
      sel <= idx_next;
      seg <= blank ? 8'hFF : {1'b1, seg_code(nib)};
    end
  end

endmodule
